fifo_pop_ctrl: RTL

FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

---
 rtl/fifo_pop_ctrl_pkg.sv | 13 +
 rtl/skid_buf2.sv | 61 ++++++
 rtl/fifo_pop_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared types and helpers for the FIFO pop controller and its two-entry skid buffer.
package fifo_pop_ctrl_pkg;

    localparam int SKID_ENTRIES = 2;

    // One address bit plus a wrap bit, so a full and an empty buffer can be told apart.
    typedef logic [1:0] skid_ptr_t;

    function automatic logic [1:0] skid_count(input skid_ptr_t wr_ptr, input skid_ptr_t rd_ptr);
        return wr_ptr - rd_ptr;
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer with write/read strobes, a synchronous clear and occupancy output.
module skid_buf2
    import fifo_pop_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_dat,
    output logic [1:0]        num,
    output logic              vld
);

    skid_ptr_t         wr_ptr_r;
    skid_ptr_t         rd_ptr_r;
    logic [DATA_W-1:0] mem_r [SKID_ENTRIES];
    logic              vld_r;
    skid_ptr_t         wr_ptr_nxt_s;
    skid_ptr_t         rd_ptr_nxt_s;

    // Next pointer values; clear has priority over both strobes.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (clr) begin
            wr_ptr_nxt_s = 2'd0;
            rd_ptr_nxt_s = 2'd0;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r + {1'b0, wr};
            rd_ptr_nxt_s = rd_ptr_r + {1'b0, rd};
        end
    end

    // Storage, pointers and the registered valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            vld_r    <= 1'b0;
            for (int i = 0; i < SKID_ENTRIES; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr && !clr) begin
                mem_r[wr_ptr_r[0]] <= wr_dat;
            end
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            vld_r    <= (skid_count(wr_ptr_nxt_s, rd_ptr_nxt_s) != 2'd0);
        end
    end

    assign rd_dat = mem_r[rd_ptr_r[0]];
    assign num    = skid_count(wr_ptr_r, rd_ptr_r);
    assign vld    = vld_r;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Turns a sync FIFO's pop / one-cycle-latency read into a valid/ready stream at full rate.
module fifo_pop_ctrl
    import fifo_pop_ctrl_pkg::*;
#(
    parameter int FIFO_DATA_W = 32,
    parameter int SKID_DEEP   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_pop,
    input  logic [FIFO_DATA_W-1:0] fifo_pop_dat,
    input  logic                   fifo_pop_dat_vld,
    input  logic                   flush,
    output logic                   out_vld,
    output logic [FIFO_DATA_W-1:0] out_dat,
    input  logic                   out_rdy,
    output logic [1:0]             buf_num,
    output logic                   err
);

    logic       inflight_r;
    logic       err_r;
    logic       xfer_s;
    logic       wr_s;
    logic       rd_s;
    logic       pop_s;
    logic [2:0] credit_used_s;
    logic [2:0] credit_lim_s;

    assign xfer_s = out_vld & out_rdy;

    // Pop only when every word already buffered or in flight still has a slot after this cycle's transfer.
    always_comb begin
        credit_used_s = {1'b0, buf_num} + {2'b00, inflight_r};
        credit_lim_s  = 3'(SKID_DEEP) + {2'b00, xfer_s};
        pop_s         = ~fifo_empty & ~flush & ~rst & (credit_used_s < credit_lim_s);
    end

    assign fifo_pop = pop_s;
    assign wr_s     = fifo_pop_dat_vld & inflight_r & ~flush;
    assign rd_s     = xfer_s & ~flush;

    // In-flight tracking and the sticky protocol-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            inflight_r <= pop_s;
            if (fifo_pop_dat_vld != inflight_r) begin
                err_r <= 1'b1;
            end
        end
    end

    assign err = err_r;

    skid_buf2 #(
        .DATA_W (FIFO_DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .wr     (wr_s),
        .wr_dat (fifo_pop_dat),
        .rd     (rd_s),
        .rd_dat (out_dat),
        .num    (buf_num),
        .vld    (out_vld)
    );

endmodule
